// File: rtl/down_counter_timer_if.sv
// down_counter_timer_if: control and status bundle between a timer and the block that drives it
interface down_counter_timer_if #(parameter int WIDTH = 4);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             underflow;
    logic             zero;
    logic             busy;
    modport master(output enable, load, data_in, auto_reload, input count, underflow, zero, busy);
    modport slave(input enable, load, data_in, auto_reload, output count, underflow, zero, busy);
endinterface

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down counter with prescaler, one-shot/periodic modes and underflow pulse
module down_counter_timer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input logic clk,
    input logic rst,
    down_counter_timer_if.slave bus
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
    state_t           r_state, w_next_state;
    logic [WIDTH-1:0] r_count, r_reload, w_next_count;
    logic [PW-1:0]    r_presc;
    logic             r_underflow, w_underflow, w_tick;
    assign w_tick = bus.enable && r_presc == PW'(PRESCALE - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_reload    <= '0;
            r_presc     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_count     <= w_next_count;
            r_underflow <= w_underflow;
            r_reload    <= bus.load ? bus.data_in : r_reload;
            r_presc     <= bus.load ? '0 : !bus.enable ? r_presc : w_tick ? '0 : r_presc + 1'b1;
        end
    end
    // load outranks a coinciding tick, so a zero-count tick is swallowed on a load edge
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_underflow  = 1'b0;
        if (bus.load) begin
            w_next_state = RUN;
            w_next_count = bus.data_in;
        end else if (r_state == RUN && w_tick) begin
            if (r_count != '0) begin
                w_next_count = r_count - 1'b1;
            end else begin
                w_underflow = 1'b1;
                if (bus.auto_reload) w_next_count = r_reload;
                else w_next_state = EXPIRED;
            end
        end
    end
    assign bus.count     = r_count;
    assign bus.underflow = r_underflow;
    assign bus.zero      = r_count == '0;
    assign bus.busy      = r_state == RUN;
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: vector table, directed corner cases and random run against a cycle model
module tb_down_counter_timer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic t_en = 1'b0, t_load = 1'b0, t_ar = 1'b0;
    logic [3:0] t_data = '0;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;

    down_counter_timer_if #(.WIDTH(4)) b0();
    down_counter_timer_if #(.WIDTH(4)) b1();
    assign b0.enable = t_en;  assign b0.load = t_load;  assign b0.data_in = t_data;  assign b0.auto_reload = t_ar;
    assign b1.enable = t_en;  assign b1.load = t_load;  assign b1.data_in = t_data;  assign b1.auto_reload = t_ar;
    down_counter_timer #(.WIDTH(4), .PRESCALE(1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    down_counter_timer #(.WIDTH(4), .PRESCALE(3)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    logic [3:0] a_cnt[2];
    logic a_uf[2], a_z[2], a_b[2];
    assign a_cnt[0] = b0.count;  assign a_uf[0] = b0.underflow;  assign a_z[0] = b0.zero;  assign a_b[0] = b0.busy;
    assign a_cnt[1] = b1.count;  assign a_uf[1] = b1.underflow;  assign a_z[1] = b1.zero;  assign a_b[1] = b1.busy;

    // reference model: mode 0=idle 1=running 2=expired; phase counts enabled cycles within a step
    int ps[2] = '{1, 3};
    int m_mode[2], m_cnt[2], m_rel[2], m_ph[2];
    bit m_uf[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_cnt[k] = 0; m_rel[k] = 0; m_ph[k] = 0; m_uf[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit ld, input bit en, input bit ar, input int d);
        bit tick;
        tick = 0;
        m_uf[k] = 0;
        if (ld) begin
            m_cnt[k] = d; m_rel[k] = d; m_ph[k] = 0; m_mode[k] = 1;
        end else begin
            if (en) begin
                m_ph[k] = (m_ph[k] + 1) % ps[k];
                tick = (m_ph[k] == 0);
            end
            if (m_mode[k] == 1 && tick) begin
                if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
                else begin
                    m_uf[k] = 1;
                    if (ar) m_cnt[k] = m_rel[k];
                    else m_mode[k] = 2;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model%0d count", k), int'(a_cnt[k]), m_cnt[k]);
            chk($sformatf("model%0d underflow", k), int'(a_uf[k]), int'(m_uf[k]));
            chk($sformatf("model%0d zero", k), int'(a_z[k]), int'(m_cnt[k] == 0));
            chk($sformatf("model%0d busy", k), int'(a_b[k]), int'(m_mode[k] == 1));
        end
    endtask

    task automatic cycle(input bit ld, input bit en, input bit ar, input logic [3:0] d);
        t_load = ld; t_en = en; t_ar = ar; t_data = d;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, ld, en, ar, int'(d));
        #1;
        chk_model();
    endtask

    typedef struct {
        bit ld; bit en; bit ar; logic [3:0] d;
        int cnt; bit uf; bit busy;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit ld, bit en, bit ar, int d, int cnt, bit uf, bit busy);
        vec_t v;
        v.ld = ld; v.en = en; v.ar = ar; v.d = 4'(d); v.cnt = cnt; v.uf = uf; v.busy = busy;
        return v;
    endfunction

    initial begin
        // idle with enable high, then one-shot of 3
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3, 3, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 2, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        // periodic reload of 2
        tbl.push_back(mk(1, 1, 1, 2, 2, 0, 1));
        for (int r = 0; r < 3; r++) begin
            tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1));
            tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1));
            tbl.push_back(mk(0, 1, 1, 0, 2, 1, 1));
        end
        // load of 7 lands on the zero tick: no pulse
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 7, 7, 0, 1));

        model_reset();
        #12;
        chk("reset count", int'(a_cnt[0]), 0);
        chk("reset zero", int'(a_z[0]), 1);
        chk("reset busy", int'(a_b[0]), 0);
        chk("reset underflow", int'(a_uf[0]), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        foreach (tbl[i]) begin
            cycle(tbl[i].ld, tbl[i].en, tbl[i].ar, tbl[i].d);
            chk($sformatf("vec%0d count", i), int'(a_cnt[0]), tbl[i].cnt);
            chk($sformatf("vec%0d underflow", i), int'(a_uf[0]), int'(tbl[i].uf));
            chk($sformatf("vec%0d busy", i), int'(a_b[0]), int'(tbl[i].busy));
            chk($sformatf("vec%0d zero", i), int'(a_z[0]), int'(tbl[i].cnt == 0));
        end

        // prescale-by-3 timer: load 5, 6 enabled cycles, 4 held, then 3 more
        cycle(1, 0, 0, 4'd5);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 4'd0);
        chk("ps3 after 6", int'(a_cnt[1]), 3);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 4'd0);
            chk("ps3 hold", int'(a_cnt[1]), 3);
        end
        cycle(0, 1, 0, 4'd0);
        cycle(0, 1, 0, 4'd0);
        chk("ps3 before step", int'(a_cnt[1]), 3);
        cycle(0, 1, 0, 4'd0);
        chk("ps3 step", int'(a_cnt[1]), 2);

        // asynchronous reset between edges at count 4
        cycle(1, 0, 1, 4'd4);
        chk("pre-reset count", int'(a_cnt[0]), 4);
        #3;
        rst = 1'b0;
        #1;
        chk("async count", int'(a_cnt[0]), 0);
        chk("async zero", int'(a_z[0]), 1);
        chk("async busy", int'(a_b[0]), 0);
        chk("async underflow", int'(a_uf[0]), 0);
        model_reset();
        #2;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, 4'd9);
            chk("post-reset idle busy", int'(a_b[0]), 0);
        end

        // random stimulus against the model
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
